// File: rtl/current_offset_calibrator.sv
// Raw ADC front end: averages 2^CAL_SHIFT samples per channel into a zero-current offset,
// then streams signed offset-corrected samples downstream over valid/ready.
module current_offset_calibrator #(
    parameter int unsigned IN_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DATA_COUNT = 1,
    parameter int unsigned CAL_SHIFT  = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_COUNT*IN_WIDTH-1:0]   in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_COUNT*DATA_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             cal_start,
    output logic                             cal_done,
    output logic [DATA_COUNT*IN_WIDTH-1:0]   offset_data
);

    localparam int unsigned ACC_WIDTH = IN_WIDTH + CAL_SHIFT;
    localparam int unsigned CNT_WIDTH = CAL_SHIFT;
    localparam logic [ACC_WIDTH:0] ROUND = (ACC_WIDTH + 1)'(1) << (CAL_SHIFT - 1);

    typedef enum logic {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 pending;
    logic [CNT_WIDTH-1:0] count;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 cal_last;
    logic                 enter_cal;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign cal_last  = (state == ST_CAL) && in_xfer && (count == '1);
    assign enter_cal = (state == ST_RUN) && pending && (!out_valid || out_ready);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CAL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_CAL: if (cal_last)  state_nx = ST_RUN;
            ST_RUN: if (enter_cal) state_nx = ST_CAL;
            default:               state_nx = ST_CAL;
        endcase
    end

    // Input acceptance; a pending recalibration blocks new input until the output drains
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_CAL:  in_ready = 1'b1;
            ST_RUN:  in_ready = !pending && (!out_valid || out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    // Sample counter, recalibration request and handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            cal_done  <= 1'b0;
        end else begin
            if ((state == ST_CAL) && in_xfer) begin
                count <= count + CNT_WIDTH'(1);
            end

            if (enter_cal) begin
                pending <= 1'b0;
            end else if ((state == ST_RUN) && cal_start) begin
                pending <= 1'b1;
            end

            if (cal_last) begin
                cal_done <= 1'b1;
            end else if (enter_cal) begin
                cal_done <= 1'b0;
            end

            if ((state == ST_RUN) && in_xfer) begin
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Per-channel accumulator, offset and output register; channel 0 sits in the MSBs
    for (genvar ch = 0; ch < int'(DATA_COUNT); ch++) begin : g_ch
        localparam int unsigned ILSB = (DATA_COUNT - 1 - ch) * IN_WIDTH;
        localparam int unsigned OLSB = (DATA_COUNT - 1 - ch) * DATA_WIDTH;

        logic        [IN_WIDTH-1:0]   code;
        logic        [ACC_WIDTH-1:0]  acc_q;
        logic        [ACC_WIDTH-1:0]  sum;
        logic        [ACC_WIDTH:0]    rounded;
        logic        [IN_WIDTH:0]     mean;
        logic        [IN_WIDTH-1:0]   offset_nx;
        logic        [IN_WIDTH-1:0]   offset_q;
        logic signed [IN_WIDTH:0]     diff;
        logic        [DATA_WIDTH-1:0] out_q;

        assign code      = in_data[ILSB +: IN_WIDTH];
        assign sum       = acc_q + ACC_WIDTH'(code);
        assign rounded   = {1'b0, sum} + ROUND;
        assign mean      = (IN_WIDTH + 1)'(rounded >> CAL_SHIFT);
        assign offset_nx = mean[IN_WIDTH] ? {IN_WIDTH{1'b1}} : mean[IN_WIDTH-1:0];
        assign diff      = signed'({1'b0, code}) - signed'({1'b0, offset_q});

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc_q    <= '0;
                offset_q <= '0;
                out_q    <= '0;
            end else begin
                if ((state == ST_CAL) && in_xfer) begin
                    acc_q <= cal_last ? '0 : sum;
                end
                if (cal_last) begin
                    offset_q <= offset_nx;
                end
                if ((state == ST_RUN) && in_xfer) begin
                    out_q <= DATA_WIDTH'(diff);
                end
            end
        end

        assign offset_data[ILSB +: IN_WIDTH] = offset_q;
        assign out_data[OLSB +: DATA_WIDTH]  = out_q;
    end

endmodule

// File: tb/tb_current_offset_calibrator.sv
// Bench for current_offset_calibrator: behavioural scoreboard model plus table vectors
// and hand sequences for backpressure, recalibration and mid-calibration reset.
module tb_current_offset_calibrator;

    localparam int unsigned IW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned DC = 2;
    localparam int unsigned CS = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DC*IW-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DC*DW-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              cal_start;
    logic              cal_done;
    logic [DC*IW-1:0]  offset_data;

    current_offset_calibrator #(
        .IN_WIDTH  (IW),
        .DATA_WIDTH(DW),
        .DATA_COUNT(DC),
        .CAL_SHIFT (CS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cal_start  (cal_start),
        .cal_done   (cal_done),
        .offset_data(offset_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: calibration averaging, recalibration handshake and expected-output queue
    logic [DC*DW-1:0] sb_q[$];
    int               m_acc[DC];
    int               m_cnt;
    logic [IW-1:0]    m_off[DC];
    bit               m_run;
    bit               m_pending;

    always @(negedge clk) begin : monitor
        bit            qv;
        bit            exp_ir;
        bit            xin;
        logic [IW-1:0] c[DC];
        int            avg;
        if (reset) begin
            for (int i = 0; i < int'(DC); i++) begin
                m_acc[i] = 0;
                m_off[i] = '0;
            end
            m_cnt     = 0;
            m_run     = 1'b0;
            m_pending = 1'b0;
            sb_q.delete();
        end else begin
            qv     = sb_q.size() != 0;
            exp_ir = !m_run || (!m_pending && (!qv || out_ready));
            check("in_ready", in_ready, exp_ir);
            check("out_valid", out_valid, qv);
            check("cal_done", cal_done, m_run);
            check("offset_data", offset_data, {m_off[0], m_off[1]});
            if (qv) check("sb_out_data", out_data, sb_q[0]);
            c[0] = in_data[2*IW-1:IW];
            c[1] = in_data[IW-1:0];
            xin  = in_valid && exp_ir;
            if (qv && out_ready) void'(sb_q.pop_front());
            if (!m_run) begin
                if (xin) begin
                    for (int i = 0; i < int'(DC); i++) m_acc[i] += int'(c[i]);
                    m_cnt++;
                    if (m_cnt == (1 << CS)) begin
                        for (int i = 0; i < int'(DC); i++) begin
                            avg      = (m_acc[i] + (1 << (CS - 1))) / (1 << CS);
                            m_off[i] = (avg > 4095) ? 12'hFFF : IW'(avg);
                            m_acc[i] = 0;
                        end
                        m_cnt = 0;
                        m_run = 1'b1;
                    end
                end
            end else if (m_pending && (!qv || out_ready)) begin
                m_run     = 1'b0;
                m_pending = 1'b0;
            end else begin
                if (xin) sb_q.push_back({DW'(int'(c[0]) - int'(m_off[0])),
                                         DW'(int'(c[1]) - int'(m_off[1]))});
                if (cal_start) m_pending = 1'b1;
            end
        end
    end

    typedef struct {
        logic [IW-1:0] c0;
        logic [IW-1:0] c1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t tbl[4];

    task automatic send(input logic [IW-1:0] c0, input logic [IW-1:0] c1);
        int n = 0;
        in_data  = {c0, c1};
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_data"}, out_data, {e0, e1});
    endtask

    task automatic pulse_cal();
        @(posedge clk);
        #1 cal_start = 1'b1;
        @(posedge clk);
        #1 cal_start = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{12'd2148, 12'd1000, 16'd100,         -16'sd1000};
        tbl[1] = '{12'd0,    12'd4095, -16'sd2048,      16'd2095};
        tbl[2] = '{12'd2048, 12'd2000, 16'd0,           16'd0};
        tbl[3] = '{12'd4095, 12'd0,    16'd2047,        -16'sd2000};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cal_start = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_cal_done", cal_done, 1'b0);
        check("rst_offset", offset_data, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Initial calibration
        for (int i = 0; i < 4; i++) send(12'd2048, 12'd2000);
        @(negedge clk);
        check("t1_cal_done", cal_done, 1'b1);
        check("t1_offset", offset_data, {12'd2048, 12'd2000});

        // Table-driven correction vectors
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            send(tbl[i].c0, tbl[i].c1);
            check_out($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1);
        end

        // Recalibration with half-up rounding on ch0 and near-full-scale ch1
        pulse_cal();
        send(12'd10, 12'd4095);
        send(12'd11, 12'd4095);
        send(12'd11, 12'd4095);
        send(12'd11, 12'd4094);
        @(negedge clk);
        check("t3_offset", offset_data, {12'd11, 12'd4095});
        @(posedge clk);
        #1;
        send(12'd11, 12'd4095);
        check_out("t3_zero", 16'd0, 16'd0);
        @(posedge clk);
        #1;
        send(12'd0, 12'd0);
        check_out("t3_neg", -16'sd11, -16'sd4095);

        // Backpressure: A stalls, B waits, then both flow in order
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(12'd100, 12'd4000);
        in_data  = {12'd50, 12'd4095};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_ready", in_ready, 1'b0);
            check("t4_hold_A", out_data, {16'd89, -16'sd95});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("t4_accept_B", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t4_B_valid", out_valid, 1'b1);
        check("t4_B_data", out_data, {16'd39, 16'd0});
        @(negedge clk);
        check("t4_drained", out_valid, 1'b0);

        // cal_start while an output is stalled
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(12'd20, 12'd100);
        pulse_cal();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_pend_done", cal_done, 1'b1);
            check("t5_pend_valid", out_valid, 1'b1);
            check("t5_pend_ready", in_ready, 1'b0);
            check("t5_hold_A", out_data, {16'd9, -16'sd3995});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("t5_final_ready", in_ready, 1'b0);
        @(negedge clk);
        check("t5_recal_done", cal_done, 1'b0);
        check("t5_recal_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        send(12'd1000, 12'd3000);
        send(12'd1000, 12'd3000);
        @(negedge clk);
        check("t5_old_offset", offset_data, {12'd11, 12'd4095});
        @(posedge clk);
        #1;
        send(12'd1000, 12'd3000);
        send(12'd1000, 12'd3000);
        @(negedge clk);
        check("t5_new_offset", offset_data, {12'd1000, 12'd3000});
        check("t5_run_again", cal_done, 1'b1);
        @(posedge clk);
        #1;
        send(12'd1000, 12'd0);
        check_out("t5_out", 16'd0, -16'sd3000);

        // Reset after two calibration samples
        pulse_cal();
        send(12'd500, 12'd500);
        send(12'd500, 12'd500);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_data", out_data, '0);
        check("t6_rst_offset", offset_data, '0);
        check("t6_rst_done", cal_done, 1'b0);
        check("t6_rst_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) send(12'd500, 12'd600);
        @(negedge clk);
        check("t6_still_cal", cal_done, 1'b0);
        @(posedge clk);
        #1;
        send(12'd500, 12'd600);
        @(negedge clk);
        check("t6_cal_done", cal_done, 1'b1);
        check("t6_offset", offset_data, {12'd500, 12'd600});

        repeat (3) @(posedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
